// File: rtl/debounce_pkg.sv
// Shared constants for the input debouncing stages: FSM state encoding and
// default parameter values.
package debounce_pkg;

  localparam logic [1:0] ENC_S_LOW    = 2'b00;
  localparam logic [1:0] ENC_S_WAIT_H = 2'b01;
  localparam logic [1:0] ENC_S_HIGH   = 2'b10;
  localparam logic [1:0] ENC_S_WAIT_L = 2'b11;

  typedef enum logic [1:0] {
    S_LOW    = ENC_S_LOW,
    S_WAIT_H = ENC_S_WAIT_H,
    S_HIGH   = ENC_S_HIGH,
    S_WAIT_L = ENC_S_WAIT_L
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_EVT_W         = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input; all stages
// clear to 0 on reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // shift the raw input through the synchronizer stages
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounced_edge_detector.sv
// Debounces a raw asynchronous input into a clean registered level with
// one-cycle rise/fall pulses and a wrapping count of accepted transitions.
module debounced_edge_detector
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int EVT_W         = DEF_EVT_W
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             D,
  output logic             Q,
  output logic             RISE,
  output logic             FALL,
  output logic             BUSY,
  output logic [EVT_W-1:0] EVT_CNT
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);

  logic             d_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK   (CLK),
    .RST_n (RST_n),
    .d     (D),
    .q     (d_s)
  );

  // next-state and registered-output decode; pulses default low every cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = CNT_ZERO;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    busy_d  = 1'b0;
    evt_d   = evt_q;
    case (state_q)
      S_LOW: begin
        q_d = 1'b0;
        if (d_s) begin
          state_d = S_WAIT_H;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
        end else begin
          state_d = S_LOW;
        end
      end
      S_WAIT_H: begin
        q_d = 1'b0;
        if (!d_s) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          q_d     = 1'b1;
          rise_d  = 1'b1;
          evt_d   = evt_q + EVT_ONE;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          busy_d = 1'b1;
        end
      end
      S_HIGH: begin
        q_d = 1'b1;
        if (!d_s) begin
          state_d = S_WAIT_L;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
        end else begin
          state_d = S_HIGH;
        end
      end
      S_WAIT_L: begin
        q_d = 1'b1;
        if (d_s) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          q_d     = 1'b0;
          fall_d  = 1'b1;
          evt_d   = evt_q + EVT_ONE;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        q_d     = 1'b0;
      end
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_LOW;
      cnt_q   <= CNT_ZERO;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= {EVT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
    end
  end

  assign Q       = q_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;
  assign BUSY    = busy_q;
  assign EVT_CNT = evt_q;

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Self-checking bench: directed scenarios plus random bouncing input, compared
// against a run-length reference model of the debouncer.
module tb_debounced_edge_detector;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       D = 1'b0;
  logic       Q, RISE, FALL, BUSY;
  logic [7:0] EVT_CNT;
  logic       Qw, RISEw, FALLw, BUSYw;
  logic [1:0] EVT_CNTw;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: delay line of sampled D, then count consecutive disagreeing samples
  bit m_pipe[$];
  bit m_q, m_rise, m_fall, m_busy;
  int m_run, m_evt;

  debounced_edge_detector dut (
    .CLK(CLK), .RST_n(RST_n), .D(D), .Q(Q), .RISE(RISE), .FALL(FALL),
    .BUSY(BUSY), .EVT_CNT(EVT_CNT)
  );

  debounced_edge_detector #(.EVT_W(2)) dut_w (
    .CLK(CLK), .RST_n(RST_n), .D(D), .Q(Qw), .RISE(RISEw), .FALL(FALLw),
    .BUSY(BUSYw), .EVT_CNT(EVT_CNTw)
  );

  always #10 CLK = ~CLK;

  function automatic void m_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
    m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
    m_run = 0; m_evt = 0;
  endfunction

  function automatic void m_step(input bit din);
    bit seen;
    seen = m_pipe.pop_front();
    m_pipe.push_back(din);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (seen != m_q) begin
      m_run++;
      if (m_run == STABLE) begin
        m_q    = seen;
        m_rise = seen;
        m_fall = !seen;
        m_evt++;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    m_busy = (m_run != 0);
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (RST_n) m_step(D);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    D = 1'b1;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({Q, RISE, FALL, BUSY, EVT_CNT} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got Q=%b R=%b F=%b B=%b E=%0d want all 0", i, Q, RISE, FALL, BUSY, EVT_CNT);
      end
    end
    D = 1'b0;
    RST_n = 1'b1;
  endtask

  task automatic test_clean_rise();
    repeat (3) tick();
    D = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_tests++;
      if ({Q, RISE, BUSY} !== {(e >= 6), (e == 6), (e >= 3 && e < 6)}) begin
        n_fail++;
        $display("FAIL clean_rise edge=%0d got Q=%b R=%b B=%b want Q=%b R=%b B=%b", e, Q, RISE, BUSY, e >= 6, e == 6, e >= 3 && e < 6);
      end
    end
    n_tests++;
    if (EVT_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL clean_rise_evt got %0d want 1", EVT_CNT);
    end
  endtask

  task automatic test_clean_fall();
    D = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_tests++;
      if ({Q, FALL, RISE, BUSY} !== {(e < 6), (e == 6), 1'b0, (e >= 3 && e < 6)}) begin
        n_fail++;
        $display("FAIL clean_fall edge=%0d got Q=%b F=%b R=%b B=%b", e, Q, FALL, RISE, BUSY);
      end
    end
    n_tests++;
    if (EVT_CNT !== 8'd2) begin
      n_fail++;
      $display("FAIL clean_fall_evt got %0d want 2", EVT_CNT);
    end
  endtask

  task automatic test_glitch();
    D = 1'b1;
    tick();
    tick();
    D = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_tests++;
      if ({Q, RISE, BUSY, EVT_CNT} !== {m_q, m_rise, m_busy, 8'(m_evt)} || Q !== 1'b0 || RISE !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch cyc=%0d got Q=%b R=%b B=%b E=%0d want Q=0 R=0 B=%b E=%0d", e, Q, RISE, BUSY, EVT_CNT, m_busy, m_evt);
      end
    end
    n_tests++;
    if ({BUSY, EVT_CNT} !== {1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL glitch_end got B=%b E=%0d want B=0 E=2", BUSY, EVT_CNT);
    end
  endtask

  task automatic test_mid_reset();
    D = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_busy got %b want 1", BUSY);
    end
    #5 RST_n = 1'b0;
    m_reset();
    #1;
    n_tests++;
    if ({Q, RISE, FALL, BUSY, EVT_CNT, Qw, BUSYw, EVT_CNTw} !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset_async got Q=%b R=%b F=%b B=%b E=%0d want all 0", Q, RISE, FALL, BUSY, EVT_CNT);
    end
    @(negedge CLK);
    RST_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_tests++;
      if ({Q, RISE, EVT_CNT} !== {(e >= 6), (e == 6), ((e >= 6) ? 8'd1 : 8'd0)}) begin
        n_fail++;
        $display("FAIL mid_reset_rise edge=%0d got Q=%b R=%b E=%0d", e, Q, RISE, EVT_CNT);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [4];
    bit         seen;
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    D = 1'b0;
    RST_n = 1'b0;
    m_reset();
    @(negedge CLK);
    RST_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      D = ~D;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        seen = m_rise | m_fall;
      end
      n_tests++;
      if (!seen || EVT_CNTw !== exp_seq[k] || (RISEw | FALLw) !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap k=%0d got E=%0d pulse=%b want E=%0d pulse=1", k, EVT_CNTw, RISEw | FALLw, exp_seq[k]);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 80; n++) begin
      D = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        tick();
        n_tests++;
        if ({Q, RISE, FALL, BUSY, EVT_CNT} !== {m_q, m_rise, m_fall, m_busy, 8'(m_evt)} ||
            {Qw, RISEw, FALLw, BUSYw, EVT_CNTw} !== {m_q, m_rise, m_fall, m_busy, 2'(m_evt)} ||
            (RISE & FALL) !== 1'b0) begin
          n_fail++;
          $display("FAIL random n=%0d got Q=%b R=%b F=%b B=%b E=%0d Ew=%0d want Q=%b R=%b F=%b B=%b E=%0d",
                   n, Q, RISE, FALL, BUSY, EVT_CNT, EVT_CNTw, m_q, m_rise, m_fall, m_busy, m_evt);
        end
      end
    end
  endtask

  initial begin
    m_reset();
    @(negedge CLK);
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
